// File: rtl/uc_arbiter_mc.sv
// uc_arbiter_mc
// Collects unit literals for the SAT engine array. Literals are preloaded from
// memory (LOAD), then taken from NUM_ENGINE engines under round-robin
// arbitration (RUN). Every accepted literal is registered once, then checked
// against a per-variable polarity table on the following cycle. The check
// drops illegal and duplicate literals, flags a conflict on opposite
// polarity, and pushes new literals into a DEPTH-entry broadcast FIFO.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   clear             : synchronous restart to LOAD (table, FIFO, counters)
//   mem_valid/mem_lit : preload literal, accepted when mem_ready is high
//   mem_done          : preload complete, moves LOAD -> RUN
//   eng_valid/eng_lit : per-engine literal, engine i at [i*LIT_W +: LIT_W]
//   eng_ready         : one-hot (or zero) grant to the winning engine
//   out_valid/out_lit : FIFO head, popped on out_valid & out_ready
//   conflict          : sticky conflict flag, conflict_var = its variable
//   idle              : RUN with nothing queued, in flight or requested
//   uc_count          : number of unique literals recorded
module uc_arbiter_mc #(
  parameter int NUM_ENGINE = 4,
  parameter int LIT_W      = 10,
  parameter int DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       mem_valid,
  input  logic [LIT_W-1:0]           mem_lit,
  input  logic                       mem_done,
  output logic                       mem_ready,
  input  logic [NUM_ENGINE-1:0]      eng_valid,
  input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
  output logic [NUM_ENGINE-1:0]      eng_ready,
  output logic                       out_valid,
  output logic [LIT_W-1:0]           out_lit,
  input  logic                       out_ready,
  output logic                       conflict,
  output logic [LIT_W-2:0]           conflict_var,
  output logic                       idle,
  output logic [LIT_W-1:0]           uc_count
);

  localparam int NVAR = 1 << (LIT_W - 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int GW   = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  localparam logic [1:0] ST_LOAD     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_CONFLICT = 2'd2;

  // 0 and -2^(LIT_W-1) both have all magnitude bits clear.
  function automatic logic lit_illegal(input logic [LIT_W-1:0] lit);
    return (lit[LIT_W-2:0] == {(LIT_W-1){1'b0}});
  endfunction

  // Low bits of the two's-complement negation depend only on the low bits.
  function automatic logic [LIT_W-2:0] lit_var(input logic [LIT_W-1:0] lit);
    return lit[LIT_W-1] ? (~lit[LIT_W-2:0] + {{(LIT_W-2){1'b0}}, 1'b1}) : lit[LIT_W-2:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic             ready_en_q, ready_en_d;
  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic             acc_valid_q, acc_valid_d;
  logic [LIT_W-1:0] acc_lit_q, acc_lit_d;
  logic [NVAR-1:0]  pos_q, pos_d, neg_q, neg_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [LIT_W-1:0] uc_count_q, uc_count_d;
  logic             conflict_q, conflict_d;
  logic [LIT_W-2:0] conflict_var_q, conflict_var_d;
  logic [LIT_W-1:0] fifo_mem_q [DEPTH];

  logic [LIT_W-1:0] eng_lit_arr_s [NUM_ENGINE];
  logic [GW-1:0]    gnt_idx_s, cand_s;
  logic             gnt_found_s, take_s;
  logic             full_s, mem_fire_s, eng_fire_s, pop_s, out_valid_s;
  logic [NUM_ENGINE-1:0] eng_ready_s;
  logic [LIT_W-2:0] chk_var_s;
  logic             chk_neg_s, proc_s, dup_s, opp_s, push_s, conf_s;

  for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_unpack
    assign eng_lit_arr_s[g] = eng_lit[g*LIT_W +: LIT_W];
  end

  // Round-robin search starting one past the last accepted engine.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = last_grant_q;
    cand_s      = last_grant_q;
    take_s      = 1'b0;
    for (int k = 1; k <= NUM_ENGINE; k++) begin
      cand_s      = GW'((int'(last_grant_q) + k) % NUM_ENGINE);
      take_s      = !gnt_found_s && eng_valid[cand_s];
      gnt_idx_s   = take_s ? cand_s : gnt_idx_s;
      gnt_found_s = gnt_found_s | take_s;
    end
  end

  // Handshakes and the registered-literal check against the polarity table.
  always_comb begin
    // The literal waiting in the check stage counts against FIFO space.
    full_s      = (count_q + {{AW{1'b0}}, acc_valid_q}) >= (AW+1)'(DEPTH);
    out_valid_s = ready_en_q && (state_q != ST_CONFLICT) && (count_q != {(AW+1){1'b0}});
    pop_s       = out_valid_s && out_ready;
    mem_ready   = ready_en_q && (state_q == ST_LOAD) && !full_s;
    eng_ready_s = {NUM_ENGINE{1'b0}};
    if (ready_en_q && (state_q == ST_RUN) && !full_s && gnt_found_s) begin
      eng_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      eng_ready_s = {NUM_ENGINE{1'b0}};
    end
    mem_fire_s = mem_valid && mem_ready;
    eng_fire_s = |(eng_valid & eng_ready_s);

    chk_var_s = lit_var(acc_lit_q);
    chk_neg_s = acc_lit_q[LIT_W-1];
    proc_s    = acc_valid_q && (state_q != ST_CONFLICT) && !lit_illegal(acc_lit_q);
    dup_s     = proc_s && (chk_neg_s ? neg_q[chk_var_s] : pos_q[chk_var_s]);
    opp_s     = proc_s && (chk_neg_s ? pos_q[chk_var_s] : neg_q[chk_var_s]);
    conf_s    = opp_s && !dup_s;
    push_s    = proc_s && !dup_s && !opp_s;
  end

  // Next-state computation; clear overrides every other input.
  always_comb begin
    state_d        = state_q;
    ready_en_d     = 1'b1;
    last_grant_d   = last_grant_q;
    acc_valid_d    = 1'b0;
    acc_lit_d      = acc_lit_q;
    pos_d          = pos_q;
    neg_d          = neg_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    uc_count_d     = uc_count_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    if (clear) begin
      state_d        = ST_LOAD;
      last_grant_d   = GW'(NUM_ENGINE - 1);
      acc_lit_d      = {LIT_W{1'b0}};
      pos_d          = {NVAR{1'b0}};
      neg_d          = {NVAR{1'b0}};
      wr_ptr_d       = {AW{1'b0}};
      rd_ptr_d       = {AW{1'b0}};
      count_d        = {(AW+1){1'b0}};
      uc_count_d     = {LIT_W{1'b0}};
      conflict_d     = 1'b0;
      conflict_var_d = {(LIT_W-1){1'b0}};
    end else begin
      case (state_q)
        ST_LOAD:     state_d = conf_s ? ST_CONFLICT : (mem_done ? ST_RUN : ST_LOAD);
        ST_RUN:      state_d = conf_s ? ST_CONFLICT : ST_RUN;
        ST_CONFLICT: state_d = ST_CONFLICT;
        default:     state_d = ST_LOAD;
      endcase
      acc_valid_d = mem_fire_s || eng_fire_s;
      acc_lit_d   = mem_fire_s ? mem_lit : eng_lit_arr_s[gnt_idx_s];
      if (eng_fire_s) begin
        last_grant_d = gnt_idx_s;
      end else begin
        last_grant_d = last_grant_q;
      end
      if (push_s) begin
        if (chk_neg_s) begin
          neg_d[chk_var_s] = 1'b1;
        end else begin
          pos_d[chk_var_s] = 1'b1;
        end
        wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        uc_count_d = uc_count_q + {{(LIT_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d   = wr_ptr_q;
        uc_count_d = uc_count_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
      if (conf_s) begin
        conflict_d     = 1'b1;
        conflict_var_d = chk_var_s;
      end else begin
        conflict_d     = conflict_q;
        conflict_var_d = conflict_var_q;
      end
    end
  end

  // State, table, FIFO pointers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      ready_en_q     <= 1'b0;
      last_grant_q   <= GW'(NUM_ENGINE - 1);
      acc_valid_q    <= 1'b0;
      acc_lit_q      <= {LIT_W{1'b0}};
      pos_q          <= {NVAR{1'b0}};
      neg_q          <= {NVAR{1'b0}};
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      count_q        <= {(AW+1){1'b0}};
      uc_count_q     <= {LIT_W{1'b0}};
      conflict_q     <= 1'b0;
      conflict_var_q <= {(LIT_W-1){1'b0}};
    end else begin
      state_q        <= state_d;
      ready_en_q     <= ready_en_d;
      last_grant_q   <= last_grant_d;
      acc_valid_q    <= acc_valid_d;
      acc_lit_q      <= acc_lit_d;
      pos_q          <= pos_d;
      neg_q          <= neg_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      uc_count_q     <= uc_count_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
    end
  end

  // FIFO storage; contents are only observed through the counted pointers.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      fifo_mem_q[wr_ptr_q] <= acc_lit_q;
    end
  end

  assign eng_ready    = eng_ready_s;
  assign out_valid    = out_valid_s;
  assign out_lit      = out_valid_s ? fifo_mem_q[rd_ptr_q] : {LIT_W{1'b0}};
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign uc_count     = uc_count_q;
  assign idle         = ready_en_q && (state_q == ST_RUN) && (count_q == {(AW+1){1'b0}})
                        && !acc_valid_q && !(|eng_valid);

endmodule
